riscv_custom_issue: RTL and testbench

//  EX-stage issue/retire sequencer directly upstream of the custom execution unit (CEU).

---
 rtl/riscv_custom_issue.sv | 156 +++++++++++++++
 tb/tb_riscv_custom_issue.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_custom_issue.sv
// EX-stage issue/retire sequencer for the custom execution unit (CEU): latches one request,
// pulses the CEU enable, waits for completion or timeout and hands the result to writeback.
module riscv_custom_issue #(
    parameter int unsigned                 ALU_OP_WIDTH   = 7,
    parameter logic [ALU_OP_WIDTH-1:0]     ALU_ADD        = ALU_OP_WIDTH'(7'b0011000),
    parameter logic [ALU_OP_WIDTH-1:0]     ALU_CLB        = ALU_OP_WIDTH'(7'b0110101),
    parameter int unsigned                 TIMEOUT_CYCLES = 8191,
    parameter int unsigned                 CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    ex_valid_i,
    output logic                    ex_ready_o,
    input  logic [ALU_OP_WIDTH-1:0] ex_operator_i,
    input  logic [31:0]             ex_operand_a_i,
    input  logic [31:0]             ex_operand_b_i,
    output logic                    ceu_enable_o,
    output logic [ALU_OP_WIDTH-1:0] ceu_operator_o,
    output logic [31:0]             ceu_operand_a_o,
    output logic [31:0]             ceu_operand_b_o,
    input  logic [31:0]             ceu_result_i,
    input  logic                    ceu_ready_i,
    output logic                    wb_valid_o,
    output logic [31:0]             wb_result_o,
    output logic                    wb_err_o,
    input  logic                    wb_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ALU_OP_WIDTH-1:0] op_q, op_d;
    logic [31:0]             a_q, a_d;
    logic [31:0]             b_q, b_d;
    logic [31:0]             result_q, result_d;
    logic                    err_q, err_d;

    logic accept;
    logic is_clb;
    logic timeout;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        err_d      = err_q;

        ex_ready_o = (state_q == S_IDLE) || ((state_q == S_RESP) && wb_ready_i);
        accept     = ex_valid_i && ex_ready_o && !flush_i;
        is_clb     = (op_q == ALU_CLB);
        timeout    = (cnt_q == CNT_MAX);

        // Acceptance is only possible from IDLE or a retiring RESP; both lead to ISSUE.
        if (accept) begin
            op_d  = ex_operator_i;
            a_d   = ex_operand_a_i;
            b_d   = ex_operand_b_i;
            err_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (flush_i) begin
                    // A launched GCD keeps running inside the CEU and must be drained.
                    state_d = is_clb ? S_DRAIN : S_IDLE;
                    cnt_d   = CNT_ONE;
                end else if (ceu_ready_i && !is_clb) begin
                    result_d = ceu_result_i;
                    state_d  = S_RESP;
                end else begin
                    cnt_d   = CNT_ONE;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    // If the GCD finishes in the flush cycle there is nothing left to drain.
                    state_d = (is_clb && !ceu_ready_i) ? S_DRAIN : S_IDLE;
                    cnt_d   = CNT_ONE;
                end else if (ceu_ready_i) begin
                    result_d = ceu_result_i;
                    state_d  = S_RESP;
                end else if (timeout) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RESP: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (wb_ready_i) begin
                    state_d = accept ? S_ISSUE : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (ceu_ready_i || timeout) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign ceu_enable_o    = (state_q == S_ISSUE);
    assign ceu_operator_o  = op_q;
    assign ceu_operand_a_o = a_q;
    assign ceu_operand_b_o = b_q;
    assign wb_valid_o      = (state_q == S_RESP);
    assign wb_result_o     = result_q;
    assign wb_err_o        = err_q;

endmodule

// File: tb/tb_riscv_custom_issue.sv
// Self-checking bench for riscv_custom_issue: a behavioural CEU stub plus a transaction-level
// model predicting latency, result and error flag of each request.
module tb_riscv_custom_issue;

    localparam int         TO     = 16;
    localparam logic [6:0] OP_ADD = 7'b0011000;
    localparam logic [6:0] OP_CLB = 7'b0110101;
    localparam logic [6:0] OP_XOR = 7'b0101111;

    logic        clk, rst, flush, ex_valid, ex_ready;
    logic [6:0]  ex_op, ceu_op;
    logic [31:0] ex_a, ex_b, ceu_a, ceu_b, ceu_res, wb_res;
    logic        ceu_en, ceu_rdy, wb_valid, wb_err, wb_ready;

    int errors = 0;
    int checks = 0;

    // CEU stub controls: non-GCD ops answer in ISSUE when stub_fast, GCD answers stub_lat
    // cycles after its enable (0 = never).
    bit          stub_fast = 1'b1;
    int          stub_lat  = 4;
    logic        gcd_busy  = 1'b0;
    logic        gcd_done  = 1'b0;
    int          gcd_left  = 0;
    logic [31:0] gcd_val   = '0;

    riscv_custom_issue #(.TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush_i         (flush),
        .ex_valid_i      (ex_valid),
        .ex_ready_o      (ex_ready),
        .ex_operator_i   (ex_op),
        .ex_operand_a_i  (ex_a),
        .ex_operand_b_i  (ex_b),
        .ceu_enable_o    (ceu_en),
        .ceu_operator_o  (ceu_op),
        .ceu_operand_a_o (ceu_a),
        .ceu_operand_b_o (ceu_b),
        .ceu_result_i    (ceu_res),
        .ceu_ready_i     (ceu_rdy),
        .wb_valid_o      (wb_valid),
        .wb_result_o     (wb_res),
        .wb_err_o        (wb_err),
        .wb_ready_i      (wb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] ctz32(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return 32'(i);
        return 32'd32;
    endfunction

    function automatic logic [31:0] gcd32(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p, q, t;
        p = x; q = y;
        while (q != 0) begin
            t = p % q; p = q; q = t;
        end
        return p;
    endfunction

    function automatic logic [31:0] ceu_fn(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == OP_ADD) return ctz32(a);
        if (op == OP_CLB) return gcd32(a, b);
        return a ^ b;
    endfunction

    assign ceu_rdy = (ceu_op == OP_CLB) ? gcd_done : stub_fast;
    assign ceu_res = (ceu_op == OP_CLB) ? gcd_val : ceu_fn(ceu_op, ceu_a, ceu_b);

    // The stub CEU ignores rst: a GCD in flight is never cancelled.
    always @(posedge clk) begin
        gcd_done <= 1'b0;
        if (ceu_en && ceu_op == OP_CLB) begin
            gcd_busy <= 1'b1;
            gcd_left <= stub_lat;
            gcd_val  <= gcd32(ceu_a, ceu_b);
        end else if (gcd_busy && gcd_left == 1) begin
            gcd_busy <= 1'b0;
            gcd_done <= 1'b1;
        end else if (gcd_busy && gcd_left > 1) begin
            gcd_left <= gcd_left - 1;
        end
    end

    // Reference model: cycle (1 = ISSUE) in which wb_valid first shows, plus result and error.
    task automatic expect_txn(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int lat, input bit fast,
                              output int exp_n, output logic [31:0] exp_res, output logic exp_err);
        int wait_cycles;
        if (op != OP_CLB) wait_cycles = fast ? 0 : -1;
        else              wait_cycles = (lat == 0) ? -1 : lat + 1;
        if (wait_cycles >= 0 && wait_cycles <= TO) begin
            exp_n = 2 + wait_cycles; exp_res = ceu_fn(op, a, b); exp_err = 1'b0;
        end else begin
            exp_n = 2 + TO; exp_res = '0; exp_err = 1'b1;
        end
    endtask

    task automatic accept_req(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        for (int i = 0; i < 60 && ex_ready !== 1'b1; i++) @(negedge clk);
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_before_accept: ex_ready=%b, expected 1", tag, ex_ready);
        end
        ex_valid = 1'b1; ex_op = op; ex_a = a; ex_b = b;
        @(negedge clk);
        ex_valid = 1'b0; ex_op = 7'($urandom); ex_a = $urandom; ex_b = $urandom;
    endtask

    // Starts at the ISSUE cycle negedge and follows the op until wb_valid rises.
    task automatic wait_resp(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int exp_n, input logic [31:0] exp_res, input logic exp_err, input string tag);
        int n, en_cnt, en_first;
        bit seen, hold_bad;
        n = 1; en_cnt = 0; en_first = -1; seen = 1'b0; hold_bad = 1'b0;
        while (n <= 60 && !seen) begin
            if (ceu_en === 1'b1) begin
                en_cnt++;
                if (en_first < 0) en_first = n;
            end
            if (ceu_op !== op || ceu_a !== a || ceu_b !== b) hold_bad = 1'b1;
            if (wb_valid === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk); n++;
            end
        end
        checks++;
        if (!seen || n != exp_n) begin
            errors++; $display("FAIL %s latency: wb_valid at cycle %0d (seen=%0b), expected %0d", tag, n, seen, exp_n);
        end
        checks++;
        if (en_cnt != 1 || en_first != 1) begin
            errors++; $display("FAIL %s enable: %0d pulses first at %0d, expected 1 pulse at 1", tag, en_cnt, en_first);
        end
        checks++;
        if (hold_bad) begin
            errors++; $display("FAIL %s operand_hold: CEU operator/operands changed, expected %h/%h/%h", tag, op, a, b);
        end
        checks++;
        if (wb_res !== exp_res) begin
            errors++; $display("FAIL %s result: got %h, expected %h", tag, wb_res, exp_res);
        end
        checks++;
        if (wb_err !== exp_err) begin
            errors++; $display("FAIL %s err: got %b, expected %b", tag, wb_err, exp_err);
        end
    endtask

    task automatic release_resp(input int stall, input logic [6:0] op, input string tag);
        logic [31:0] r0;
        logic        e0;
        bit          bad;
        r0 = wb_res; e0 = wb_err; bad = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (wb_valid !== 1'b1 || wb_res !== r0 || wb_err !== e0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL %s resp_hold: wb outputs changed during stall, expected %h/%b held", tag, r0, e0);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL %s retire: wb_valid=%b ex_ready=%b, expected 0/1", tag, wb_valid, ex_ready);
        end
        checks++;
        if (ceu_op !== op) begin
            errors++; $display("FAIL %s op_after_done: ceu_operator=%h, expected %h", tag, ceu_op, op);
        end
    endtask

    task automatic run_txn(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input bit fast, input int stall, input string tag);
        int          exp_n;
        logic [31:0] exp_res;
        logic        exp_err;
        stub_lat = lat; stub_fast = fast;
        expect_txn(op, a, b, lat, fast, exp_n, exp_res, exp_err);
        accept_req(op, a, b, tag);
        wait_resp(op, a, b, exp_n, exp_res, exp_err, tag);
        release_resp(stall, op, tag);
        stub_fast = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({ex_ready, ceu_en, wb_valid, wb_err} !== 4'b1000) begin
            errors++; $display("FAIL %s ctrl: ready/en/valid/err=%b%b%b%b, expected 1000", tag, ex_ready, ceu_en, wb_valid, wb_err);
        end
        checks++;
        if (ceu_op !== OP_ADD) begin
            errors++; $display("FAIL %s operator: got %h, expected %h", tag, ceu_op, OP_ADD);
        end
        checks++;
        if (ceu_a !== 32'd0 || ceu_b !== 32'd0 || wb_res !== 32'd0) begin
            errors++; $display("FAIL %s data: a=%h b=%h res=%h, expected all 0", tag, ceu_a, ceu_b, wb_res);
        end
    endtask

    task automatic test_reset();
        check_reset_outputs("reset");
    endtask

    task automatic test_ffs();
        run_txn(OP_ADD, 32'h0000_0100, 32'h1234_5678, 0, 1'b1, 0, "ffs_0x100");
        run_txn(OP_XOR, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 0, 1'b1, 1, "xor_fast");
    endtask

    task automatic test_gcd();
        run_txn(OP_CLB, 32'd48, 32'd18, 7, 1'b1, 2, "gcd_48_18");
        run_txn(OP_CLB, 32'd1000, 32'd7, 1, 1'b1, 0, "gcd_min_lat");
    endtask

    task automatic test_timeout();
        run_txn(OP_ADD, 32'h0000_0010, 32'd3, 0, 1'b0, 1, "timeout_never_ready");
        run_txn(OP_CLB, 32'd84, 32'd36, 15, 1'b1, 0, "ready_at_timeout");
        run_txn(OP_CLB, 32'd84, 32'd36, 16, 1'b1, 0, "clb_timeout");
    endtask

    task automatic test_back_to_back();
        int          exp_n;
        logic [31:0] exp_res, r0;
        logic        exp_err, e0;
        bit          bad;
        stub_fast = 1'b1; stub_lat = 4;
        accept_req(OP_ADD, 32'h0000_8000, 32'd0, "b2b_first");
        wait_resp(OP_ADD, 32'h0000_8000, 32'd0, 2, 32'd15, 1'b0, "b2b_first");
        r0 = wb_res; e0 = wb_err; bad = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (wb_valid !== 1'b1 || wb_res !== r0 || wb_err !== e0 || ex_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL b2b stall_hold: outputs changed while wb_ready low, expected %h/%b held", r0, e0);
        end
        wb_ready = 1'b1; ex_valid = 1'b1; ex_op = OP_CLB; ex_a = 32'd48; ex_b = 32'd18;
        #1;
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++; $display("FAIL b2b ready_with_wb_ready: ex_ready=%b, expected 1", ex_ready);
        end
        @(negedge clk);
        wb_ready = 1'b0; ex_valid = 1'b0; ex_a = $urandom; ex_b = $urandom;
        checks++;
        if (ceu_en !== 1'b1 || ceu_op !== OP_CLB || ceu_a !== 32'd48 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL b2b second_issue: en=%b op=%h a=%h valid=%b, expected 1/%h/30/0", ceu_en, ceu_op, ceu_a, wb_valid, OP_CLB);
        end
        expect_txn(OP_CLB, 32'd48, 32'd18, 4, 1'b1, exp_n, exp_res, exp_err);
        wait_resp(OP_CLB, 32'd48, 32'd18, exp_n, exp_res, exp_err, "b2b_second");
        release_resp(0, OP_CLB, "b2b_second");
    endtask

    // Drain ends the cycle after the CEU's done pulse; returns the cycle ex_ready came back.
    task automatic watch_drain(input int start_n, input string tag, output int n_ready);
        bit bad;
        int n;
        n = start_n; bad = 1'b0;
        while (ex_ready !== 1'b1 && n < 60) begin
            if (wb_valid !== 1'b0) bad = 1'b1;
            @(negedge clk); n++;
        end
        n_ready = n;
        checks++;
        if (bad) begin
            errors++; $display("FAIL %s drain_no_valid: wb_valid asserted during drain, expected 0", tag);
        end
    endtask

    task automatic test_flush_drain();
        int n_ready;
        stub_lat = 10;
        accept_req(OP_CLB, 32'd1000, 32'd7, "flush_wait");
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL flush_wait drain_entry: ex_ready=%b wb_valid=%b, expected 0/0", ex_ready, wb_valid);
        end
        watch_drain(4, "flush_wait", n_ready);
        checks++;
        if (n_ready != 10 + 3) begin
            errors++; $display("FAIL flush_wait drain_len: ex_ready back at cycle %0d, expected %0d", n_ready, 13);
        end
        run_txn(OP_XOR, 32'h0000_00FF, 32'h0000_0F00, 0, 1'b1, 0, "after_drain");
    endtask

    task automatic test_flush_misc();
        int n_ready;
        stub_fast = 1'b1;
        ex_valid = 1'b1; flush = 1'b1; ex_op = OP_ADD; ex_a = 32'd1; ex_b = 32'd0;
        @(negedge clk);
        ex_valid = 1'b0; flush = 1'b0;
        checks++;
        if (ceu_en !== 1'b0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL flush_beats_valid: en=%b ready=%b, expected 0/1", ceu_en, ex_ready);
        end

        accept_req(OP_XOR, 32'd5, 32'd6, "flush_issue");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL flush_issue: valid=%b ready=%b, expected 0/1", wb_valid, ex_ready);
        end

        accept_req(OP_ADD, 32'h0000_0004, 32'd0, "flush_resp");
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1) begin
            errors++; $display("FAIL flush_resp pre: wb_valid=%b, expected 1", wb_valid);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
            errors++; $display("FAIL flush_resp: valid=%b ready=%b, expected 0/1", wb_valid, ex_ready);
        end

        stub_lat = 5;
        accept_req(OP_CLB, 32'd91, 32'd35, "flush_issue_clb");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (ex_ready !== 1'b0) begin
            errors++; $display("FAIL flush_issue_clb drain_entry: ex_ready=%b, expected 0", ex_ready);
        end
        watch_drain(2, "flush_issue_clb", n_ready);
        checks++;
        if (n_ready != 5 + 3) begin
            errors++; $display("FAIL flush_issue_clb drain_len: ex_ready back at cycle %0d, expected %0d", n_ready, 8);
        end
    endtask

    task automatic test_reset_mid_wait();
        run_txn(OP_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 0, 1'b1, 0, "pre_reset");
        stub_lat = 12;
        accept_req(OP_CLB, 32'd1000, 32'd7, "reset_mid_wait");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_wait");
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        run_txn(OP_ADD, 32'h0000_0040, 32'd9, 0, 1'b1, 0, "post_reset");
    endtask

    task automatic test_random();
        logic [6:0]  op;
        logic [31:0] a, b;
        int          lat, stall;
        bit          fast;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0:       op = OP_ADD;
                1:       op = OP_XOR;
                default: op = OP_CLB;
            endcase
            if (op == OP_CLB) begin
                a = 32'($urandom_range(1, 5000));
                b = 32'($urandom_range(1, 5000));
            end else begin
                a = $urandom; b = $urandom;
            end
            lat   = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 17) : $urandom_range(1, 14);
            fast  = ($urandom_range(0, 7) != 0);
            stall = $urandom_range(0, 3);
            run_txn(op, a, b, lat, fast, stall, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_a = '0; ex_b = '0; wb_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_ffs();
        test_gcd();
        test_timeout();
        test_back_to_back();
        test_flush_drain();
        test_flush_misc();
        test_reset_mid_wait();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
